// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: MULT/MULTU (shift-add) and DIV/DIVU (restoring),
// one bit per cycle, delivering {HI,LO} as a single-cycle double-write pulse.
module mdu_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int ITER       = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [DATA_WIDTH-1:0]   src_a,
    input  logic [DATA_WIDTH-1:0]   src_b,
    input  logic                    cancel,
    output logic                    busy,
    output logic                    double_en,
    output logic [2*DATA_WIDTH-1:0] double_wdata
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    // Handshake: start is taken only in IDLE without cancel; busy covers CALC and
    // DONE; double_en pulses for the single DONE cycle with double_wdata valid.
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;
    logic [W-1:0]    opnd;
    logic [2*W-1:0]  acc;

    logic            signed_op, sa, sb;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      sum, sh, diff;
    logic [2*W-1:0]  acc_step;
    logic [W-1:0]    hi_f, lo_f;
    logic [2*W-1:0]  res;

    always_comb begin
        signed_op = ~op[0];
        sa        = signed_op & src_a[W-1];
        sb        = signed_op & src_b[W-1];
        mag_a     = sa ? -src_a : src_a;
        mag_b     = sb ? -src_b : src_b;
    end

    // acc holds {partial product, multiplier} for multiply, {remainder, dividend} for divide.
    always_comb begin
        sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        sh   = {acc[2*W-1:W], acc[W-1]};
        diff = sh - {1'b0, opnd};
        if (is_div) begin
            if (!diff[W]) acc_step = {diff[W-1:0], acc[W-2:0], 1'b1};
            else          acc_step = {sh[W-1:0],   acc[W-2:0], 1'b0};
        end else begin
            acc_step = {sum, acc[W-1:1]};
        end
        hi_f = neg_r ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
        lo_f = neg_q ? -acc_step[W-1:0]   : acc_step[W-1:0];
        if (is_div) res = {hi_f, lo_f};
        else        res = neg_q ? -acc_step : acc_step;
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !cancel) state_nxt = CALC;
            CALC: begin
                if (cancel)           state_nxt = IDLE;
                else if (cnt == LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt          <= '0;
            is_div       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            opnd         <= '0;
            acc          <= '0;
            busy         <= 1'b0;
            double_en    <= 1'b0;
            double_wdata <= '0;
        end else begin
            busy      <= (state_nxt != IDLE);
            double_en <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        // A zero divisor leaves the all-ones quotient unsigned.
                        neg_q  <= (sa ^ sb) & ~(op[1] & (src_b == '0));
                        neg_r  <= sa;
                        opnd   <= op[1] ? mag_b : mag_a;
                        acc    <= {{W{1'b0}}, op[1] ? mag_a : mag_b};
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (state_nxt == DONE) double_wdata <= res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the 5-stage MIPS core.
- Executes MULT, MULTU, DIV and DIVU one bit per cycle.
- Delivers the 64-bit {HI,LO} result as a single one-cycle write pulse to the register-file double-write port: LO goes to register 32, HI goes to register 33.
- Sits beside the EX stage. The pipeline controller stalls on busy and kills the operation with cancel on an exception or flush.

Parameters:
- DATA_WIDTH, 32, operand width; HI and LO are each DATA_WIDTH bits.
- ITER, 32, number of iteration cycles (must equal DATA_WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- start  input  1  launches an operation; accepted only when busy=0.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- src_a  input  DATA_WIDTH  multiplicand or dividend (rs); sampled with start.
- src_b  input  DATA_WIDTH  multiplier or divisor (rt); sampled with start.
- cancel  input  1  synchronous abort of the in-flight operation.
- busy  output  1  high while an operation is in flight, including the write cycle.
- double_en  output  1  one-cycle write strobe to the register file.
- double_wdata  output  64  {HI, LO}; HI is [63:32], LO is [31:0].

Behaviour:
- State machine states: IDLE, CALC, DONE. The state, counter, operand and result registers are all registered.
- Reset (rstn=0 at a clock edge):
  - state goes to IDLE and the counter to 0.
  - busy=0, double_en=0, double_wdata=0.
  - Reset overrides start and cancel, and takes effect even mid-operation.
- IDLE:
  - If start=1, latch op, src_a and src_b and go to CALC with counter=0.
  - Signed ops convert operands to magnitudes and record the result signs.
- CALC:
  - One iteration per cycle; the counter increments each cycle.
  - After ITER cycles (counter=ITER-1), go to DONE.
  - Multiply: shift-add, 2*DATA_WIDTH-bit unsigned product of the magnitudes.
  - Divide: restoring divide on the magnitudes.
- DONE:
  - Load double_wdata with the final result, assert double_en for exactly one cycle, then return to IDLE.
- busy is a registered output: 1 in the cycles the state is CALC or DONE, 0 in IDLE.
- double_en is a registered output: 1 only while the state is DONE.
- Latency:
  - start sampled at edge 0, so busy=1 from cycle 1.
  - double_en=1 in cycle ITER+1 (cycle 33).
  - busy=0 in cycle ITER+2.
  - A new start can be accepted at the edge ending cycle ITER+2 at the earliest; back-to-back throughput is one operation per 34 cycles.
- start while busy=1 (CALC or DONE): ignored; no queuing.
- cancel:
  - In CALC: go to IDLE at the next edge. busy=0 the following cycle, double_en is never asserted, double_wdata keeps its previous value.
  - In DONE: no effect; the write completes.
  - In IDLE: no effect, and it suppresses a start sampled in the same cycle.
- Result rules:
  - MULT: two's-complement 64-bit product, negated when the operand signs differ.
  - MULTU: unsigned 64-bit product.
  - DIV: quotient truncated toward zero; the remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (src_b=0, DIV or DIVU): the unit still takes the full latency. Result is LO=32'hFFFFFFFF and HI=src_a unchanged.
- DIV overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0x00000000.
- double_wdata holds the last completed result until the next DONE or reset.
- This block never writes register 0 and never drives the single-word write port.

Test Plan:
- Reset then MULTU, src_a=0xFFFFFFFF, src_b=0xFFFFFFFF, start at edge 0 -> busy=1 cycles 1..33; double_en=1 only in cycle 33 with double_wdata=0xFFFFFFFE_00000001; busy=0 in cycle 34.
- MULT, src_a=0xFFFFFFFD (-3), src_b=5 -> double_wdata=0xFFFFFFFF_FFFFFFF1. Repeat with MULT 0x80000000 × 0x80000000 -> 0x40000000_00000000.
- DIV, src_a=0xFFFFFFF9 (-7), src_b=2 -> 0xFFFFFFFF_FFFFFFFD (HI=-1, LO=-3). DIVU, src_a=100, src_b=7 -> 0x00000002_0000000E.
- Boundary divides:
  - DIVU 0x12345678 / 0 -> 0x12345678_FFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000.
  - Both take the full 33-cycle latency.
- Handshake checks:
  - Second start with different operands in cycle 5 -> ignored; only the first result is written, one double_en pulse.
  - cancel in cycle 10 -> busy=0 in cycle 11, no double_en, double_wdata unchanged from the prior result.
- Reset mid-operation:
  - rstn=0 in cycle 20 of a DIVU -> busy=0, double_en=0, double_wdata=0 after the edge.
  - A start issued after reset release completes normally 33 cycles later.
